// File: rtl/gp_preprocess_stage_if.sv
// Handshake bundle for gp_preprocess_stage: operand request side plus g/p response side.
// slave = the stage itself, master = the environment that sources operands and sinks g/p.
interface gp_preprocess_stage_if #(parameter int WIDTH = 4);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_g;
   logic [WIDTH-1:0] out_p;
   logic             out_cin;

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      output in_ready, out_valid, out_g, out_p, out_cin
   );

   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      input  in_ready, out_valid, out_g, out_p, out_cin
   );
endinterface

// File: rtl/gp_preprocess_stage.sv
// Generate/propagate pre-processing ahead of the prefix tree, with a 2-entry skid buffer.
// Optional subtract support (b inverted, carry-in forced to 1) is enabled by macro GP_SUB_EN.
module gp_preprocess_stage #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   gp_preprocess_stage_if.slave io_bus
);

   typedef struct packed {
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      logic             cin;
   } ent_t;

   // Occupancy doubles as the state encoding.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           r_state;
   ent_t             r_head;
   ent_t             r_tail;
   logic             r_in_ready;
   logic             r_out_valid;

   logic             w_sub;
   logic             w_cin_eff;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_g;
   logic [WIDTH-1:0] w_p;
   ent_t             w_new;
   logic             w_push;
   logic             w_pop;

`ifdef GP_SUB_EN
   assign w_sub = io_bus.in_sub;
`else
   logic w_unused_sub;
   assign w_sub        = 1'b0;
   assign w_unused_sub = io_bus.in_sub;
`endif

   assign w_b       = w_sub ? ~io_bus.in_b : io_bus.in_b;
   assign w_cin_eff = w_sub | io_bus.in_cin;

   // Bit 0 generate absorbs the carry-in; p stays raw because the sum stage needs p[0].
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign w_p[i] = io_bus.in_a[i] ^ w_b[i];
      if (i == 0) begin : g_fold
         assign w_g[i] = (io_bus.in_a[i] & w_b[i]) | (w_p[i] & w_cin_eff);
      end else begin : g_plain
         assign w_g[i] = io_bus.in_a[i] & w_b[i];
      end
   end

   assign w_new  = '{g: w_g, p: w_p, cin: w_cin_eff};
   assign w_push = io_bus.in_valid & r_in_ready;
   assign w_pop  = r_out_valid & io_bus.out_ready;

   // Handshake flags are registered from the next state so in_ready never sees out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= EMPTY;
         r_head      <= '0;
         r_tail      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_push) begin
                  r_head      <= w_new;
                  r_state     <= ONE;
                  r_out_valid <= 1'b1;
               end
            end
            ONE: begin
               if (w_push && w_pop) begin
                  r_head <= w_new;
               end else if (w_push) begin
                  r_tail     <= w_new;
                  r_state    <= FULL;
                  r_in_ready <= 1'b0;
               end else if (w_pop) begin
                  r_state     <= EMPTY;
                  r_out_valid <= 1'b0;
               end
            end
            FULL: begin
               if (w_pop) begin
                  r_head     <= r_tail;
                  r_state    <= ONE;
                  r_in_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= EMPTY;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign io_bus.in_ready  = r_in_ready;
   assign io_bus.out_valid = r_out_valid;
   assign io_bus.out_g     = r_head.g;
   assign io_bus.out_p     = r_head.p;
   assign io_bus.out_cin   = r_head.cin;

endmodule

// File: doc/gp_preprocess_stage.md
Name: gp_preprocess_stage

Overview:
Registered operand pre-processing stage for the tree adders, sitting directly upstream of the group generate cells. It accepts operand pairs plus carry-in over a valid/ready handshake and computes bitwise generate (a&b) and propagate (a^b). The carry-in is folded into bit 0 generate. Results are buffered in a 2-entry skid buffer so the prefix tree downstream can stall without creating a combinational ready path back to the source.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand word valid
in_ready  output  1  stage can accept a word this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in
in_sub  input  1  subtract request; used only when GP_SUB_EN is defined, otherwise ignored
out_valid  output  1  g/p word valid
out_ready  input  1  downstream accepts word
out_g  output  WIDTH  bitwise generate, cin folded into bit 0
out_p  output  WIDTH  bitwise propagate, unmodified (sum stage needs p[0])
out_cin  output  1  carry-in that went with the word

Behaviour:
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready, both sampled at the rising clk edge.
- Compute, per bit i: g[i] = a[i]&b'[i] and p[i] = a[i]^b'[i].
  - b' = in_b, or ~in_b when subtracting (see Optional Feature).
  - Bit 0 is then folded: g[0] = (a[0]&b'[0]) | (p[0]&cin_eff).
  - out_p[0] keeps the raw a[0]^b'[0].
- Buffering: 2-entry FIFO (head, tail) with occupancy count 0..2.
- State machine, encoded in count:
  - EMPTY (0): in transfer -> ONE.
  - ONE (1): in only -> FULL; out only -> EMPTY; in and out together -> stays ONE, new word becomes head.
  - FULL (2): out transfer -> ONE; no input can be accepted.
- in_ready = (count != 2), driven from a register only, with no combinational path from out_ready.
- out_valid = (count != 0). out_g, out_p and out_cin always present the head entry; they are don't-care when out_valid=0 but are held at 0 after reset.
- Latency: a word accepted at edge t appears on the outputs with out_valid=1 immediately after edge t when the buffer was empty. Throughput is 1 word/cycle when out_ready is held high.
- Ordering: strict FIFO order, no drop, no duplication.
- Stall: while out_valid=1 and out_ready=0, head outputs stay stable and out_valid stays high.
- Reset (rst_n low, asynchronous): count=0, out_valid=0, out_g/out_p/out_cin=0, in_ready=1. Inputs are ignored while reset is asserted.
- Reset mid-operation: all buffered words are discarded and nothing is emitted after release.
- Widths: no arithmetic carries are formed in this block; all paths are bitwise except the bit 0 fold.

Optional Feature:
Macro GP_SUB_EN.
- Defined: when in_sub=1, the stage uses b' = ~in_b and cin_eff = 1, ignoring in_cin, and out_cin=1; the downstream adder then produces a-b. When in_sub=0, the stage behaves as if the macro were not defined.
- Not defined: in_sub is unused, b' = in_b, cin_eff = in_cin, and out_cin = in_cin.

Test Plan:
- WIDTH=4, a=1011, b=0110, cin=0, out_ready=1 -> next cycle out_valid=1, out_g=0010, out_p=1101, out_cin=0.
- Same operands with cin=1 -> out_g=0011, out_p=1101, out_cin=1.
- GP_SUB_EN defined, a=0101, b=0011, in_sub=1, cin=0 -> out_g=0101, out_p=1001, out_cin=1. Without the macro -> out_g=0001, out_p=0110, out_cin=0.
- Backpressure: out_ready=0, push 3 words W0,W1,W2 -> W0,W1 accepted, in_ready=0 after the second accept, W2 held by the source. Then raise out_ready -> W0, W1, W2 emitted in order with no gaps beyond 1 cycle and no loss.
- Streaming with out_ready=1 and in_valid=1 for 8 cycles of random operands -> 8 consecutive out_valid cycles. Every output matches a&b / a^b with the bit 0 fold, in order.
- Assert rst_n low asynchronously mid-clock with 2 words buffered -> out_valid=0, outputs=0 and in_ready=1 immediately. After release no stale word appears.
